// File: rtl/lsu.sv
// RV32I load/store unit: turns an ALU effective address into one data-memory
// transaction and returns aligned, extended load data for writeback.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = 4;
  localparam int unsigned RDW  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state;
  logic            op_write;
  logic [2:0]      op_f3;
  logic [1:0]      op_off;
  logic [RDW-1:0]  op_rd;

  logic            accept_c;
  logic            err_c;
  logic [BEW-1:0]  be_c;
  logic [XLEN-1:0] wdata_c;
  logic [7:0]      rbyte_c;
  logic [15:0]     rhalf_c;
  logic [XLEN-1:0] load_ext_c;

  assign req_ready = (state == IDLE);
  assign accept_c  = req_valid && (state == IDLE);

  // Misalignment and illegal width/sign combinations, evaluated on the live request.
  always_comb begin
    err_c = 1'b0;
    case (funct3)
      3'b000:  err_c = 1'b0;
      3'b001:  err_c = addr[0];
      3'b010:  err_c = |addr[1:0];
      3'b100:  err_c = mem_write;
      3'b101:  err_c = mem_write | addr[0];
      default: err_c = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated write data; loads always read the full word.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          be_c    = BEW'(4'b0001 << addr[1:0]);
          wdata_c = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_c    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{store_data[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = store_data;
        end
      endcase
    end
  end

  // Lane select and sign/zero extension of returning read data.
  always_comb begin
    rbyte_c = dmem_rdata[7:0];
    case (op_off)
      2'd0:    rbyte_c = dmem_rdata[7:0];
      2'd1:    rbyte_c = dmem_rdata[15:8];
      2'd2:    rbyte_c = dmem_rdata[23:16];
      default: rbyte_c = dmem_rdata[31:24];
    endcase
    rhalf_c = op_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_f3)
      3'b000:  load_ext_c = {{24{rbyte_c[7]}}, rbyte_c};
      3'b100:  load_ext_c = {24'd0, rbyte_c};
      3'b001:  load_ext_c = {{16{rhalf_c[15]}}, rhalf_c};
      3'b101:  load_ext_c = {16'd0, rhalf_c};
      default: load_ext_c = dmem_rdata;
    endcase
  end

  // Control FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_write   <= 1'b0;
      op_f3      <= 3'd0;
      op_off     <= 2'd0;
      op_rd      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rd    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            op_write <= mem_write;
            op_f3    <= funct3;
            op_off   <= addr[1:0];
            op_rd    <= rd_addr;
            if (err_c) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rd    <= rd_addr;
            end else begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {addr[XLEN-1:2], 2'b00};
              dmem_be    <= be_c;
              dmem_wdata <= wdata_c;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (op_write) begin
              state      <= IDLE;
              resp_valid <= 1'b1;
              resp_rd    <= op_rd;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state      <= IDLE;
            resp_valid <= 1'b1;
            resp_we    <= 1'b1;
            resp_rd    <= op_rd;
            resp_data  <= load_ext_c;
          end
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: transaction-level reference model checked every cycle, with
// directed cases and randomized ops over a randomly stalling memory.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        resp_valid;
  logic        resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_write(mem_write), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd_addr(rd_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic int unsigned op_size(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic bit op_err(input bit w, input logic [2:0] f3, input logic [1:0] off);
    if (f3[1:0] == 2'b11) return 1'b1;
    if (f3[2] && (w || f3[1:0] == 2'b10)) return 1'b1;
    return (int'(off) % int'(op_size(f3))) != 0;
  endfunction

  function automatic logic [3:0] model_be(input bit w, input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be = 4'h0;
    int sz = int'(op_size(f3));
    if (!w) return 4'hF;
    for (int i = 0; i < 4; i++)
      if (i >= int'(off) && i < int'(off) + sz) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] wd = 32'h0;
    int sz = int'(op_size(f3));
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % sz) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    int sz = int'(op_size(f3));
    logic [31:0] mask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
    logic [31:0] v = (rdata >> (8*int'(off))) & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- model state ----------------
  bit          m_busy, m_need_gnt;
  bit          m_w;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_sd;
  logic [4:0]  m_rd;
  int          m_acc;
  bit          e_rv, e_we, e_err;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  int          ncyc   = 0;
  int          n_resp = 0;
  int          last_lat;
  logic [31:0] last_data;
  logic        last_err, last_we;
  logic [4:0]  last_rd;

  // Single compare process: mid-cycle check of outputs, then advance the model
  // with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      m_busy = 1'b0; m_need_gnt = 1'b0; e_rv = 1'b0;
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_ctl", {dmem_req, dmem_we, dmem_be, resp_valid, resp_we, resp_err, resp_rd}, 32'h0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_rdata", resp_data, 32'h0);
    end else begin
      chk("req_ready", req_ready, !m_busy);
      chk("dmem_req", dmem_req, m_busy && m_need_gnt);
      if (m_busy && m_need_gnt) begin
        chk("dmem_addr", dmem_addr, {m_addr[31:2], 2'b00});
        chk("dmem_we", dmem_we, m_w);
        chk("dmem_be", dmem_be, model_be(m_w, m_f3, m_addr[1:0]));
        if (m_w) chk("dmem_wdata", dmem_wdata, model_wdata(m_f3, m_sd));
      end
      chk("resp_valid", resp_valid, e_rv);
      if (e_rv) begin
        chk("resp_we", resp_we, e_we);
        chk("resp_err", resp_err, e_err);
        chk("resp_rd", resp_rd, e_rd);
        chk("resp_data", resp_data, e_data);
        last_lat = ncyc - m_acc; last_data = resp_data; last_err = resp_err;
        last_we = resp_we; last_rd = resp_rd;
        n_resp++;
      end
      e_rv = 1'b0;
      if (!m_busy) begin
        if (req_valid) begin
          m_w = mem_write; m_f3 = funct3; m_addr = addr; m_sd = store_data;
          m_rd = rd_addr; m_acc = ncyc;
          if (op_err(mem_write, funct3, addr[1:0])) begin
            e_rv = 1'b1; e_err = 1'b1; e_we = 1'b0; e_data = 32'h0; e_rd = rd_addr;
          end else begin
            m_busy = 1'b1; m_need_gnt = 1'b1;
          end
        end
      end else if (m_need_gnt) begin
        if (dmem_gnt) begin
          m_need_gnt = 1'b0;
          if (m_w) begin
            m_busy = 1'b0;
            e_rv = 1'b1; e_err = 1'b0; e_we = 1'b0; e_data = 32'h0; e_rd = m_rd;
          end
        end
      end else if (dmem_rvalid) begin
        m_busy = 1'b0;
        e_rv = 1'b1; e_err = 1'b0; e_we = 1'b1; e_rd = m_rd;
        e_data = model_load(m_f3, m_addr[1:0], dmem_rdata);
      end
    end
  end

  // ---------------- memory responder ----------------
  int          gnt_pct = 100;
  int          rv_pct  = 100;
  bit          use_fix = 1'b0;
  logic [31:0] rdata_fix = 32'h0;

  always @(posedge clk) begin
    #2;
    dmem_gnt    = (int'($urandom_range(99)) < gnt_pct);
    dmem_rvalid = (int'($urandom_range(99)) < rv_pct);
    dmem_rdata  = use_fix ? rdata_fix : $urandom;
  end

  // ---------------- driver ----------------
  task automatic do_op(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd);
    int t = 0;
    @(posedge clk); #2;
    while (!req_ready && t < 300) begin
      @(posedge clk); #2; t++;
    end
    if (t >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles", t);
    end
    req_valid = 1'b1; mem_write = w; funct3 = f3; addr = a; store_data = sd; rd_addr = rd;
    @(posedge clk); #2;
    req_valid = 1'b0; mem_write = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; store_data = $urandom; rd_addr = 5'($urandom);
  endtask

  task automatic wait_resp();
    int start = n_resp;
    int t = 0;
    while (n_resp == start && t < 300) begin
      @(negedge clk); #1; t++;
    end
    if (n_resp == start) begin
      n_chk++; n_fail++;
      $display("FAIL resp_timeout: no resp_valid within %0d cycles", t);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'h0; store_data = 32'h0; rd_addr = 5'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Stores with immediate grant
    do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1);
    chk("sw_be", dmem_be, 32'hF);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_we", dmem_we, 1'b1);
    wait_resp();
    chk("sw_lat", 32'(last_lat), 32'd2);
    chk("sw_resp_we", last_we, 1'b0);

    do_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd2);
    chk("sb_be", dmem_be, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    wait_resp();
    do_op(1'b1, 3'b001, 32'h102, 32'h00001234, 5'd3);
    chk("sh_be", dmem_be, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h12341234);
    wait_resp();

    // Loads with fixed read data
    use_fix = 1'b1; rdata_fix = 32'h00008000;
    do_op(1'b0, 3'b000, 32'h101, 32'h0, 5'd4);
    wait_resp();
    chk("lb_data", last_data, 32'hFFFFFF80);
    chk("lb_lat", 32'(last_lat), 32'd3);
    do_op(1'b0, 3'b100, 32'h101, 32'h0, 5'd4);
    wait_resp();
    chk("lbu_data", last_data, 32'h00000080);
    rdata_fix = 32'h80010000;
    do_op(1'b0, 3'b001, 32'h102, 32'h0, 5'd6);
    wait_resp();
    chk("lh_data", last_data, 32'hFFFF8001);
    do_op(1'b0, 3'b010, 32'h104, 32'h0, 5'd5);
    wait_resp();
    chk("lw_rd", last_rd, 32'd5);
    chk("lw_we", last_we, 1'b1);
    chk("lw_data", last_data, 32'h80010000);

    // Errors: misaligned LW, misaligned SH, illegal funct3
    do_op(1'b0, 3'b010, 32'h102, 32'h0, 5'd7);
    chk("err_lw_noreq", dmem_req, 1'b0);
    wait_resp();
    chk("err_lw_err", last_err, 1'b1);
    chk("err_lw_lat", 32'(last_lat), 32'd1);
    do_op(1'b1, 3'b001, 32'h101, 32'h55, 5'd8);
    chk("err_sh_noreq", dmem_req, 1'b0);
    wait_resp();
    chk("err_sh_err", last_err, 1'b1);
    do_op(1'b0, 3'b011, 32'h100, 32'h0, 5'd9);
    wait_resp();
    chk("err_f3_err", last_err, 1'b1);
    chk("err_f3_data", last_data, 32'h0);

    // Grant withheld 4 cycles with spurious rvalid in REQ, then rvalid delayed 3 cycles
    gnt_pct = 0; rv_pct = 100; rdata_fix = 32'h0BADF00D;
    do_op(1'b0, 3'b010, 32'h200, 32'h0, 5'd10);
    repeat (4) @(posedge clk);
    gnt_pct = 100; rv_pct = 0;
    repeat (3) @(posedge clk);
    rv_pct = 100;
    wait_resp();
    chk("stall_lat", 32'(last_lat), 32'd9);
    chk("stall_data", last_data, 32'h0BADF00D);

    // Reset while waiting for read data
    rv_pct = 0;
    do_op(1'b0, 3'b010, 32'h300, 32'h0, 5'd11);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", dmem_req, 1'b0);
    chk("arst_ready", req_ready, 1'b1);
    chk("arst_be", dmem_be, 32'h0);
    chk("arst_addr", dmem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; rv_pct = 100;
    repeat (3) @(posedge clk);
    do_op(1'b0, 3'b101, 32'h302, 32'h0, 5'd12);
    wait_resp();
    chk("post_rst_data", last_data, 32'h00000BAD);

    // Randomized ops over a randomly stalling memory
    use_fix = 1'b0;
    for (int n = 0; n < 300; n++) begin
      gnt_pct = int'($urandom_range(100, 25));
      rv_pct  = int'($urandom_range(100, 25));
      do_op(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom));
      wait_resp();
    end
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
